deser_sync_framer: RTL and testbench
====================================

Name: deser_sync_framer

Overview:
- Sits directly downstream of the bit deserializer. It consumes that block's parallel word output and the same enable.
- Recovers word timing by mirroring the deserializer's bit counter, and acquires lock on a periodic sync word.
- Strips the sync words and buffers payload words in a small FIFO with a valid/ready output handshake toward the transport layer.

Parameters:
- DATA_WIDTH, 8: word width; must equal the upstream deserializer width.
- SYNC_WORD, 8'hA5: sync pattern; DATA_WIDTH bits wide.
- SYNC_PERIOD, 16: words per frame, including the one sync slot at index 0; range 2..256.
- LOCK_COUNT, 4: consecutive sync words needed to declare lock; >=1.
- UNLOCK_COUNT, 3: consecutive missing sync slots that drop lock; >=1.
- FIFO_DEPTH, 4: payload FIFO entries; power of 2, >=2.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- rst, input, 1: asynchronous, active-low reset.
- enable, input, 1: same signal that drives the upstream deserializer enable.
- parallel_data, input, DATA_WIDTH: word from the upstream deserializer.
- out_data, output, DATA_WIDTH: FIFO head word.
- out_valid, output, 1: FIFO non-empty.
- out_ready, input, 1: consumer accepts out_data when out_valid && out_ready.
- locked, output, 1: high in the LOCKED state.
- overflow, output, 1: one-cycle pulse when a payload word is dropped because the FIFO is full.
- fifo_level, output, $clog2(FIFO_DEPTH)+1: current occupancy.

Behaviour:
- Reset (rst=0, asynchronous): state=SEARCH, all counters 0, FIFO empty.
  - Outputs: out_data=0, out_valid=0, locked=0, overflow=0, fifo_level=0.
- Word strobe:
  - bit_cnt counts 0..DATA_WIDTH-1 while enable=1.
  - word_stb is registered: word_stb <= enable && bit_cnt==DATA_WIDTH-1.
  - In the cycle word_stb=1, parallel_data holds a freshly completed word, which is sampled. No other cycle samples parallel_data.
  - First word_stb occurs DATA_WIDTH+1 cycles after enable rises, then every DATA_WIDTH cycles.
- enable=0 (any cycle):
  - bit_cnt=0, word_stb=0, state=SEARCH, match/miss/index counters=0.
  - FIFO flushed (out_valid=0, fifo_level=0).
  - locked falls on the next edge.
- FSM, evaluated only on word_stb:
  - SEARCH: word==SYNC_WORD -> match_cnt=1; if LOCK_COUNT==1 go to LOCKED, else go to CHECK. Otherwise stay.
  - CHECK: word==SYNC_WORD -> match_cnt+1; on reaching LOCK_COUNT go to LOCKED. Non-sync word -> SEARCH, match_cnt=0.
  - LOCKED entry: word index idx=1 and miss_cnt=0. The sync word that completed lock occupies slot 0.
  - LOCKED, idx!=0: word pushed to FIFO unconditionally, with no sync comparison.
  - LOCKED, idx==0: word==SYNC_WORD -> miss_cnt=0, word discarded. Mismatch -> miss_cnt+1, word discarded. miss_cnt reaching UNLOCK_COUNT -> SEARCH with counters cleared. FIFO contents retained on lock loss.
  - idx wraps SYNC_PERIOD-1 -> 0.
- locked: registered; equals (state==LOCKED).
- FIFO:
  - Push = LOCKED && word_stb && idx!=0.
  - Pop = out_valid && out_ready.
  - out_data/out_valid reflect the head. A pushed word is visible at the outputs the cycle after the push edge (first-word fall-through from storage).
  - Full and push without pop: word dropped, overflow=1 for one cycle, level unchanged.
  - Full and push with pop: both performed, no overflow, level stays FIFO_DEPTH.
  - Empty and pop requested: ignored, since out_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data holds its last value when empty; reset value 0.
- Reset or enable drop mid-word: partial word is discarded; realignment restarts from bit 0.

Test Plan:
- Reset, then enable=1 with serial stream 8'hA5 x4 followed by 8'h11,8'h22: locked=1 after the 4th sync word_stb; out_data=8'h11 then 8'h22 with out_ready=1; sync words never appear at out_data.
- Lock acquisition broken: A5,A5,3C,A5,A5,A5,A5: locked stays 0 through 3C, then rises after the 4th consecutive A5 (7th word).
- Locked with SYNC_PERIOD=16, slot 0 replaced by 8'h00 for 2 frames then A5 restored: locked stays 1. With 3 consecutive corrupted slots: locked=0 on the 3rd; payload already in the FIFO still drains.
- out_ready=0 while locked for 5 payload words (FIFO_DEPTH=4): fifo_level=4 and a single overflow pulse on the 5th. Then out_ready=1: out_data sequence equals the first 4 words.
- FIFO full and a push coinciding with a pop: fifo_level stays 4, overflow=0, and ordering is preserved.
- enable dropped mid-frame, or rst pulsed low mid-word: locked=0, out_valid=0, fifo_level=0 on the next edge. Re-enable requires LOCK_COUNT sync words to relock; first word_stb occurs DATA_WIDTH+1 cycles after enable rises.

Source files
------------

// File: rtl/deser_sync_framer.sv
// rtl/deser_sync_framer.sv - word alignment, sync-word lock, sync stripping and payload FIFO
module deser_sync_framer #(
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD    = 8'hA5,
  parameter int                    SYNC_PERIOD  = 16,
  parameter int                    LOCK_COUNT   = 4,
  parameter int                    UNLOCK_COUNT = 3,
  parameter int                    FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [DATA_WIDTH-1:0]         parallel_data,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          locked,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int IW = $clog2(SYNC_PERIOD);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_COUNT + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {S_SEARCH, S_CHECK, S_LOCKED} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  word_stb_q, word_stb_d;
  logic [MW-1:0]         match_cnt_q, match_cnt_d;
  logic [UW-1:0]         miss_cnt_q, miss_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  locked_q, locked_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                  stb;
  logic                  is_sync;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  wr_en;
  logic [LW-1:0]         count_after_pop;

  // A stale strobe must never act once enable has dropped.
  assign stb     = word_stb_q & enable;
  assign is_sync = (parallel_data == SYNC_WORD);

  // Mirror of the deserializer bit counter; strobe marks a freshly completed word.
  always_comb begin
    bit_cnt_d  = '0;
    word_stb_d = 1'b0;
    if (enable) begin
      bit_cnt_d  = (bit_cnt_q == BW'(DATA_WIDTH - 1)) ? '0 : bit_cnt_q + 1'b1;
      word_stb_d = (bit_cnt_q == BW'(DATA_WIDTH - 1));
    end
  end

  // Word timing registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q  <= '0;
      word_stb_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      word_stb_q <= word_stb_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_SEARCH;
    else      state_q <= state_d;
  end

  // FSM next state plus match/miss/slot counters, advanced only on a word strobe.
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    idx_d       = idx_q;
    if (!enable) begin
      state_d     = S_SEARCH;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
      idx_d       = '0;
    end else if (stb) begin
      case (state_q)
        S_SEARCH: begin
          if (is_sync) begin
            match_cnt_d = MW'(1);
            if (LOCK_COUNT == 1) begin
              state_d     = S_LOCKED;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
              idx_d       = IW'(1);
            end else begin
              state_d = S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (is_sync) begin
            match_cnt_d = match_cnt_q + 1'b1;
            if (match_cnt_q + 1'b1 == MW'(LOCK_COUNT)) begin
              state_d     = S_LOCKED;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
              idx_d       = IW'(1);
            end
          end else begin
            state_d     = S_SEARCH;
            match_cnt_d = '0;
          end
        end
        S_LOCKED: begin
          idx_d = (idx_q == IW'(SYNC_PERIOD - 1)) ? '0 : idx_q + 1'b1;
          if (idx_q == '0) begin
            if (is_sync) begin
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
              if (miss_cnt_q + 1'b1 == UW'(UNLOCK_COUNT)) begin
                state_d     = S_SEARCH;
                match_cnt_d = '0;
                miss_cnt_d  = '0;
                idx_d       = '0;
              end
            end
          end
        end
        default: begin
          state_d     = S_SEARCH;
          match_cnt_d = '0;
          miss_cnt_d  = '0;
          idx_d       = '0;
        end
      endcase
    end
  end

  // FSM outputs: registered lock flag and the payload push request.
  always_comb begin
    locked_d = (state_d == S_LOCKED);
    push     = stb && (state_q == S_LOCKED) && (idx_q != '0);
  end

  // FIFO pointer, occupancy and head bookkeeping; enable low flushes but keeps out_data.
  always_comb begin
    full            = (count_q == LW'(FIFO_DEPTH));
    pop             = (count_q != '0) && out_ready;
    wr_en           = push && (!full || pop);
    overflow_d      = push && full && !pop;
    count_after_pop = count_q - LW'(pop);
    wr_ptr_d        = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d        = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d         = count_after_pop + LW'(wr_en);
    out_data_d      = out_data_q;
    if (wr_en && count_after_pop == '0) begin
      out_data_d = parallel_data;
    end else if (count_d != '0) begin
      out_data_d = mem_q[rd_ptr_d];
    end
    if (!enable) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      out_data_d = out_data_q;
    end
  end

  // Counter, flag and FIFO control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      idx_q       <= '0;
      locked_q    <= 1'b0;
      overflow_q  <= 1'b0;
      out_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      idx_q       <= idx_d;
      locked_q    <= locked_d;
      overflow_q  <= overflow_d;
      out_data_q  <= out_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= parallel_data;
  end

  assign out_data   = out_data_q;
  assign out_valid  = (count_q != '0);
  assign locked     = locked_q;
  assign overflow   = overflow_q;
  assign fifo_level = count_q;

endmodule

// File: tb/tb_deser_sync_framer.sv
// tb/tb_deser_sync_framer.sv - directed table, corner sequences and random stream against a queue model
module tb_deser_sync_framer;

  localparam int DW       = 8;
  localparam int PERIOD   = 16;
  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 3;
  localparam int DEPTH    = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] parallel_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       locked;
  logic       overflow;
  logic [2:0] fifo_level;

  deser_sync_framer dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .parallel_data (parallel_data),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .locked        (locked),
    .overflow      (overflow),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit rand_ready = 0;

  // reference model state
  bit         m_locked = 0;
  int         m_run    = 0;
  int         m_miss   = 0;
  int         m_idx    = 0;
  bit         m_ovf    = 0;
  logic [7:0] m_last   = 8'h00;
  logic [7:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_run = 0; m_miss = 0; m_idx = 0; m_ovf = 0;
    m_last = 8'h00;
    q.delete();
  endtask

  // one clock edge of the behavioural model, using the inputs present before that edge
  task automatic model_edge(input bit stb, input logic [7:0] w);
    bit pop, push;
    if (!enable) begin
      m_locked = 0; m_run = 0; m_miss = 0; m_idx = 0; m_ovf = 0;
      q.delete();
      return;
    end
    pop  = (q.size() != 0) && out_ready;
    push = 0;
    if (stb) begin
      if (!m_locked) begin
        m_run = (w == SYNC) ? m_run + 1 : 0;
        if (m_run == LOCK_N) begin
          m_locked = 1; m_idx = 1; m_miss = 0; m_run = 0;
        end
      end else begin
        if (m_idx != 0)     push = 1;
        else if (w == SYNC) m_miss = 0;
        else                m_miss++;
        if (m_miss == UNLOCK_N) begin
          m_locked = 0; m_miss = 0; m_idx = 0; m_run = 0;
        end else begin
          m_idx = (m_idx + 1) % PERIOD;
        end
      end
    end
    m_ovf = push && (q.size() == DEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (push && !m_ovf) q.push_back(w);
    if (q.size() != 0) m_last = q[0];
  endtask

  task automatic check_all();
    chk("locked",     locked,     m_locked);
    chk("out_valid",  out_valid,  q.size() != 0);
    chk("fifo_level", fifo_level, q.size());
    chk("overflow",   overflow,   m_ovf);
    chk("out_data",   out_data,   m_last);
  endtask

  task automatic tick(input bit stb);
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    model_edge(stb, parallel_data);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send_word(input logic [7:0] w);
    parallel_data = w;
    repeat (DW - 1) tick(0);
    tick(1);
  endtask

  task automatic restart();
    enable = 1'b0;
    tick(0);
    enable = 1'b1;
    tick(0);
  endtask

  task automatic relock();
    restart();
    repeat (LOCK_N) send_word(SYNC);
    chk("relock", locked, 1'b1);
  endtask

  task automatic payload(input int n);
    for (int i = 0; i < n; i++) send_word(8'($urandom_range(0, 255)));
  endtask

  typedef struct {
    bit         restart;
    logic [7:0] word;
    bit         rdy;
    bit         exp_locked;
    int         exp_level;
    bit         exp_ovf;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;

    vecs[0]  = '{1, 8'hA5, 1, 0, 0, 0, 8'h00};
    vecs[1]  = '{0, 8'hA5, 1, 0, 0, 0, 8'h00};
    vecs[2]  = '{0, 8'h3C, 1, 0, 0, 0, 8'h00};
    vecs[3]  = '{0, 8'hA5, 1, 0, 0, 0, 8'h00};
    vecs[4]  = '{0, 8'hA5, 1, 0, 0, 0, 8'h00};
    vecs[5]  = '{0, 8'hA5, 1, 0, 0, 0, 8'h00};
    vecs[6]  = '{0, 8'hA5, 1, 1, 0, 0, 8'h00};
    vecs[7]  = '{1, 8'hA5, 1, 0, 0, 0, 8'h00};
    vecs[8]  = '{0, 8'hA5, 1, 0, 0, 0, 8'h00};
    vecs[9]  = '{0, 8'hA5, 1, 0, 0, 0, 8'h00};
    vecs[10] = '{0, 8'hA5, 1, 1, 0, 0, 8'h00};
    vecs[11] = '{0, 8'h11, 1, 1, 1, 0, 8'h11};
    vecs[12] = '{0, 8'h22, 1, 1, 1, 0, 8'h22};
    vecs[13] = '{0, 8'h33, 1, 1, 1, 0, 8'h33};
    vecs[14] = '{0, 8'h44, 0, 1, 2, 0, 8'h33};
    vecs[15] = '{0, 8'h55, 0, 1, 3, 0, 8'h33};
    vecs[16] = '{0, 8'h66, 0, 1, 4, 0, 8'h33};
    vecs[17] = '{0, 8'h77, 0, 1, 4, 1, 8'h33};

    rst = 1'b0; enable = 1'b0; parallel_data = 8'h00; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_locked",   locked,     1'b0);
    chk("reset_valid",    out_valid,  1'b0);
    chk("reset_level",    fifo_level, 3'd0);
    chk("reset_overflow", overflow,   1'b0);
    chk("reset_data",     out_data,   8'h00);
    rst = 1'b1;

    // directed table: lock acquisition, broken acquisition, payload and overflow
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].restart) restart();
      out_ready = vecs[i].rdy;
      send_word(vecs[i].word);
      chk("vec_locked",   locked,     vecs[i].exp_locked);
      chk("vec_level",    fifo_level, vecs[i].exp_level);
      chk("vec_overflow", overflow,   vecs[i].exp_ovf);
      chk("vec_data",     out_data,   vecs[i].exp_data);
    end

    // drain the full FIFO: 33 44 55 66 in order, overflow pulse already gone
    parallel_data = 8'h88;
    out_ready = 1'b1;
    tick(0); chk("drain1_data", out_data, 8'h44); chk("drain1_ovf", overflow, 1'b0);
    tick(0); chk("drain2_data", out_data, 8'h55);
    tick(0); chk("drain3_data", out_data, 8'h66); chk("drain3_level", fifo_level, 3'd1);
    tick(0); chk("drain4_valid", out_valid, 1'b0); chk("drain4_data", out_data, 8'h66);
    repeat (DW - 5) tick(0);
    tick(1);

    // full FIFO with push and pop on the same edge
    out_ready = 1'b1;
    relock();
    out_ready = 1'b0;
    send_word(8'hC1); send_word(8'hC2); send_word(8'hC3); send_word(8'hC4);
    chk("full_level", fifo_level, 3'd4);
    parallel_data = 8'hC5;
    repeat (DW - 1) tick(0);
    out_ready = 1'b1;
    tick(1);
    chk("coinc_level", fifo_level, 3'd4);
    chk("coinc_ovf",   overflow,   1'b0);
    chk("coinc_head",  out_data,   8'hC2);
    parallel_data = 8'hC6;
    tick(0); chk("coinc_d3", out_data, 8'hC3);
    tick(0); chk("coinc_d4", out_data, 8'hC4);
    tick(0); chk("coinc_d5", out_data, 8'hC5);
    tick(0); chk("coinc_empty", fifo_level, 3'd0);
    repeat (DW - 5) tick(0);
    tick(1);

    // corrupted sync slots: two misses tolerated, three drop lock, FIFO retained
    out_ready = 1'b1;
    relock();
    payload(PERIOD - 1); send_word(8'h00); chk("miss1_locked", locked, 1'b1);
    payload(PERIOD - 1); send_word(8'h00); chk("miss2_locked", locked, 1'b1);
    payload(PERIOD - 1); send_word(SYNC);  chk("resync_locked", locked, 1'b1);
    payload(PERIOD - 1); send_word(8'h00); chk("miss1b_locked", locked, 1'b1);
    payload(PERIOD - 1); send_word(8'h00); chk("miss2b_locked", locked, 1'b1);
    out_ready = 1'b0;
    payload(PERIOD - 1); send_word(8'h00);
    chk("miss3_locked", locked, 1'b0);
    chk("miss3_level", fifo_level, 3'd4);
    out_ready = 1'b1;
    parallel_data = 8'h5A;
    repeat (4) tick(0);
    chk("unlock_drained", fifo_level, 3'd0);

    // enable dropped mid-frame and mid-word
    relock();
    out_ready = 1'b0;
    send_word(8'hD1); send_word(8'hD2);
    parallel_data = 8'hD3;
    repeat (3) tick(0);
    enable = 1'b0;
    tick(0);
    chk("endrop_locked", locked, 1'b0);
    chk("endrop_valid",  out_valid, 1'b0);
    chk("endrop_level",  fifo_level, 3'd0);
    enable = 1'b1;
    tick(0);
    repeat (LOCK_N - 1) send_word(SYNC);
    chk("endrop_not_yet", locked, 1'b0);
    send_word(SYNC);
    chk("endrop_relocked", locked, 1'b1);

    // asynchronous reset mid-word
    send_word(8'hE1);
    parallel_data = 8'hE2;
    repeat (2) tick(0);
    rst = 1'b0;
    #1;
    chk("rst_locked", locked,     1'b0);
    chk("rst_valid",  out_valid,  1'b0);
    chk("rst_level",  fifo_level, 3'd0);
    chk("rst_data",   out_data,   8'h00);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(0);
    repeat (LOCK_N) send_word(SYNC);
    chk("rst_relocked", locked, 1'b1);

    // randomized stream against the model
    rand_ready = 1;
    for (int it = 0; it < 3; it++) begin
      relock();
      for (int n = 0; n < 150; n++) begin
        if ($urandom_range(0, 99) < 2) begin
          parallel_data = 8'($urandom_range(0, 255));
          repeat ($urandom_range(0, DW - 2)) tick(0);
          enable = 1'b0;
          tick(0);
          enable = 1'b1;
          tick(0);
        end else begin
          if (!m_locked)
            w = ($urandom_range(0, 99) < 85) ? SYNC : 8'($urandom_range(0, 255));
          else if (m_idx == 0)
            w = ($urandom_range(0, 99) < 70) ? SYNC : 8'($urandom_range(0, 255));
          else
            w = 8'($urandom_range(0, 255));
          send_word(w);
        end
      end
    end
    rand_ready = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
